// File: rtl/edic_pkg.sv
// Purpose: shared types and widths for the RAM/bus arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package edic_pkg;

    localparam int STEP_W = 3;   // control-unit step counter width
    localparam int DATA_W = 8;   // data bus width
    localparam int CNT_W  = 8;   // burst and cooldown counter width (limits 1..255)

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_WAIT,
        ARB_GRANT,
        ARB_ADDR,
        ARB_DATA,
        ARB_COOL
    } arb_state_t;

endpackage

// File: rtl/ram_bus_arbiter.sv
// Purpose: shares RAM and data bus between the CPU control unit and a loader port; loader gets bounded bursts at instruction boundaries.
// Latency: handshake at t -> address strobe t+1 -> data strobe t+2 -> o_ldRValid t+3; 3 cycles per loader access.
// Backpressure: o_ldReady only in GRANT while i_ldReq is held and the burst limit is not reached; the CPU is frozen via o_cpuStall while the loader owns RAM.
//
// Ports:
//   i_clk, i_nReset                  clock (rising edge), asynchronous active-low reset
//   i_cpuStep                        current control-unit step; STALL_STEP marks an instruction boundary
//   i_cpuRamAddressEn/WriteNEn/OE    CPU RAM strobes, passed to the RAM while the CPU owns it
//   o_cpuStall                       freezes the CPU step counter / instruction register
//   i_ldReq, o_ldGnt                 loader ownership request (level) and grant
//   o_ldReady, i_ldValid             access handshake; i_ldWrite/i_ldAddr/i_ldWData sampled on it
//   o_ldRData, o_ldRValid            read data (held) and its 1-cycle valid pulse
//   o_ramAddressEn/WriteNEn/OE       RAM strobes (WriteNEn active low)
//   o_busDrive, o_busData, i_busData data bus drive enable, driven value, readback
module ram_bus_arbiter
    import edic_pkg::*;
#(
    parameter int unsigned       AW         = 8,
    parameter logic [STEP_W-1:0] STALL_STEP = '0,
    parameter int unsigned       MAX_BURST  = 16,
    parameter int unsigned       COOLDOWN   = 8
) (
    input  logic              i_clk,
    input  logic              i_nReset,
    input  logic [STEP_W-1:0] i_cpuStep,
    input  logic              i_cpuRamAddressEn,
    input  logic              i_cpuRamWriteNEn,
    input  logic              i_cpuRamOE,
    output logic              o_cpuStall,
    input  logic              i_ldReq,
    output logic              o_ldGnt,
    output logic              o_ldReady,
    input  logic              i_ldValid,
    input  logic              i_ldWrite,
    input  logic [AW-1:0]     i_ldAddr,
    input  logic [DATA_W-1:0] i_ldWData,
    output logic [DATA_W-1:0] o_ldRData,
    output logic              o_ldRValid,
    output logic              o_ramAddressEn,
    output logic              o_ramWriteNEn,
    output logic              o_ramOE,
    output logic              o_busDrive,
    output logic [DATA_W-1:0] o_busData,
    input  logic [DATA_W-1:0] i_busData
);

    localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] COOL_LAST   = CNT_W'(COOLDOWN - 1);

    arb_state_t        state;
    arb_state_t        stateNext;
    logic [CNT_W-1:0]  burstCnt;
    logic [CNT_W-1:0]  coolCnt;
    logic [AW-1:0]     ldAddrQ;
    logic [DATA_W-1:0] ldWDataQ;
    logic              ldWriteQ;
    logic              ldReady;
    logic              accept;

    assign o_ldReady = ldReady;
    assign accept    = ldReady & i_ldValid;

    always_comb begin
        stateNext      = state;
        ldReady        = 1'b0;
        o_cpuStall     = 1'b0;
        o_ldGnt        = 1'b0;
        o_ramAddressEn = i_cpuRamAddressEn;
        o_ramWriteNEn  = i_cpuRamWriteNEn;
        o_ramOE        = i_cpuRamOE;
        o_busDrive     = 1'b0;
        o_busData      = '0;

        unique case (state)
            ARB_IDLE: begin
                if (i_ldReq) stateNext = ARB_WAIT;
            end
            ARB_WAIT: begin
                // Stall is raised in the boundary cycle itself so the step
                // counter never advances past it.
                if (!i_ldReq) begin
                    stateNext = ARB_IDLE;
                end else if (i_cpuStep == STALL_STEP) begin
                    o_cpuStall = 1'b1;
                    stateNext  = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                o_cpuStall     = 1'b1;
                o_ldGnt        = 1'b1;
                o_ramAddressEn = 1'b0;
                o_ramWriteNEn  = 1'b1;
                o_ramOE        = 1'b0;
                // Ready is withheld on the exit cycle so a presented access
                // is never mistaken for an accepted one.
                if (!i_ldReq || (burstCnt >= BURST_LIMIT)) begin
                    stateNext = ARB_COOL;
                end else begin
                    ldReady = 1'b1;
                    if (i_ldValid) stateNext = ARB_ADDR;
                end
            end
            ARB_ADDR: begin
                o_cpuStall     = 1'b1;
                o_ldGnt        = 1'b1;
                o_ramAddressEn = 1'b1;
                o_ramWriteNEn  = 1'b1;
                o_ramOE        = 1'b0;
                o_busDrive     = 1'b1;
                o_busData      = DATA_W'(ldAddrQ);
                stateNext      = ARB_DATA;
            end
            ARB_DATA: begin
                o_cpuStall     = 1'b1;
                o_ldGnt        = 1'b1;
                o_ramAddressEn = 1'b0;
                o_ramWriteNEn  = !ldWriteQ;
                o_ramOE        = !ldWriteQ;
                o_busDrive     = ldWriteQ;
                o_busData      = ldWriteQ ? ldWDataQ : '0;
                stateNext      = ARB_GRANT;
            end
            ARB_COOL: begin
                if (coolCnt == COOL_LAST) stateNext = ARB_IDLE;
            end
            default: stateNext = ARB_IDLE;
        endcase

        // Reset acts on the strobes immediately so a write in flight is cut
        // off in the same cycle rather than at the next edge.
        if (!i_nReset) begin
            o_ramAddressEn = 1'b0;
            o_ramWriteNEn  = 1'b1;
            o_ramOE        = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_nReset) begin
        if (!i_nReset) begin
            state      <= ARB_IDLE;
            burstCnt   <= '0;
            coolCnt    <= '0;
            ldAddrQ    <= '0;
            ldWDataQ   <= '0;
            ldWriteQ   <= 1'b0;
            o_ldRData  <= '0;
            o_ldRValid <= 1'b0;
        end else begin
            state      <= stateNext;
            o_ldRValid <= 1'b0;

            if (accept) begin
                ldAddrQ  <= i_ldAddr;
                ldWDataQ <= i_ldWData;
                ldWriteQ <= i_ldWrite;
            end

            if (state == ARB_DATA) begin
                if (burstCnt < BURST_LIMIT) burstCnt <= burstCnt + CNT_W'(1);
                if (!ldWriteQ) begin
                    o_ldRData  <= i_busData;
                    o_ldRValid <= 1'b1;
                end
            end

            if ((state != ARB_COOL) && (stateNext == ARB_COOL)) begin
                burstCnt <= '0;
                coolCnt  <= '0;
            end else if (state == ARB_COOL) begin
                coolCnt <= coolCnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Purpose: randomized self-checking bench for ram_bus_arbiter against a transaction-level loader/RAM model.
// Latency: expects address strobe 1 cycle and data strobe 2 cycles after handshake, read valid 3 cycles after.
// Backpressure: the bench loader only presents accesses while it expects the grant window to be open.
module tb_ram_bus_arbiter;

    localparam logic [2:0] STALL = 3'd0;

    logic       i_clk = 1'b0;
    logic       i_nReset;
    logic [2:0] i_cpuStep;
    logic       i_cpuRamAddressEn, i_cpuRamWriteNEn, i_cpuRamOE;
    logic       o_cpuStall, i_ldReq, o_ldGnt, o_ldReady, i_ldValid, i_ldWrite;
    logic [7:0] i_ldAddr, i_ldWData, o_ldRData;
    logic       o_ldRValid, o_ramAddressEn, o_ramWriteNEn, o_ramOE, o_busDrive;
    logic [7:0] o_busData, i_busData;

    int errors = 0;
    int checks = 0;

    // RAM contents as seen by the RAM, and what the loader believes it wrote.
    logic [7:0] mem    [256] = '{default: 8'h00};
    logic [7:0] shadow [256] = '{default: 8'h00};
    logic [7:0] ramAddr = 8'h00;

    bit         cpuRun = 1'b0;
    bit         pendRv = 1'b0;
    logic [7:0] pendData = 8'h00;
    int         accCnt;

    always #5 i_clk = ~i_clk;

    ram_bus_arbiter #(
        .AW(8), .STALL_STEP(STALL), .MAX_BURST(16), .COOLDOWN(8)
    ) dut (
        .i_clk(i_clk), .i_nReset(i_nReset), .i_cpuStep(i_cpuStep),
        .i_cpuRamAddressEn(i_cpuRamAddressEn), .i_cpuRamWriteNEn(i_cpuRamWriteNEn),
        .i_cpuRamOE(i_cpuRamOE), .o_cpuStall(o_cpuStall), .i_ldReq(i_ldReq),
        .o_ldGnt(o_ldGnt), .o_ldReady(o_ldReady), .i_ldValid(i_ldValid),
        .i_ldWrite(i_ldWrite), .i_ldAddr(i_ldAddr), .i_ldWData(i_ldWData),
        .o_ldRData(o_ldRData), .o_ldRValid(o_ldRValid), .o_ramAddressEn(o_ramAddressEn),
        .o_ramWriteNEn(o_ramWriteNEn), .o_ramOE(o_ramOE), .o_busDrive(o_busDrive),
        .o_busData(o_busData), .i_busData(i_busData)
    );

    // RAM model; only loader traffic is modelled since the CPU side of the bus is not.
    assign i_busData = o_ramOE ? mem[ramAddr] : 8'h00;
    always @(posedge i_clk) begin
        if (o_ldGnt) begin
            if (o_ramAddressEn) ramAddr <= o_busData;
            if (!o_ramWriteNEn) mem[ramAddr] <= o_busData;
        end
    end

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; the CPU step counter moves unless stalled.
    task automatic nextCyc();
        logic s;
        s = o_cpuStall;
        @(posedge i_clk);
        #1;
        if (cpuRun && !s) i_cpuStep = i_cpuStep + 3'd1;
    endtask

    task automatic randCpu();
        i_cpuRamAddressEn = 1'($urandom);
        i_cpuRamWriteNEn  = 1'($urandom);
        i_cpuRamOE        = 1'($urandom);
    endtask

    task automatic expRam(input string tag, input logic aEn, input logic wN,
                          input logic oe, input logic drv, input logic [7:0] d);
        checkEq({tag, ".addrEn"}, 32'(o_ramAddressEn), 32'(aEn));
        checkEq({tag, ".writeN"}, 32'(o_ramWriteNEn), 32'(wN));
        checkEq({tag, ".oe"}, 32'(o_ramOE), 32'(oe));
        checkEq({tag, ".drive"}, 32'(o_busDrive), 32'(drv));
        if (drv) checkEq({tag, ".data"}, 32'(o_busData), 32'(d));
    endtask

    task automatic chkPass(input string tag);
        expRam(tag, i_cpuRamAddressEn, i_cpuRamWriteNEn, i_cpuRamOE, 1'b0, 8'h00);
        checkEq({tag, ".gnt"}, 32'(o_ldGnt), 0);
        checkEq({tag, ".ready"}, 32'(o_ldReady), 0);
    endtask

    // Request the RAM and wait for the boundary; stall may only appear once the
    // request has been seen for a cycle (mayNow says it already has).
    task automatic acquire(input bit mayNow);
        bit may;
        bit got;
        bit expStall;
        may = mayNow;
        got = 1'b0;
        i_ldReq = 1'b1;
        cpuRun = 1'b1;
        for (int n = 0; n < 24 && !got; n++) begin
            randCpu();
            @(negedge i_clk);
            expStall = may && (i_cpuStep == STALL);
            checkEq("wait.stall", 32'(o_cpuStall), 32'(expStall));
            chkPass("wait");
            got = expStall;
            may = 1'b1;
            nextCyc();
        end
        checkEq("wait.reachedBoundary", 32'(got), 1);
    endtask

    // One loader access starting in a GRANT cycle.
    task automatic access(input bit wr, input logic [7:0] a, input logic [7:0] d, input bit dropReq);
        i_ldValid = 1'b1;
        i_ldWrite = wr;
        i_ldAddr  = a;
        i_ldWData = d;
        @(negedge i_clk);
        checkEq("grant.ready", 32'(o_ldReady), 1);
        checkEq("grant.gnt", 32'(o_ldGnt), 1);
        checkEq("grant.stall", 32'(o_cpuStall), 1);
        checkEq("grant.rvalid", 32'(o_ldRValid), 32'(pendRv));
        if (pendRv) checkEq("grant.rdata", 32'(o_ldRData), 32'(pendData));
        expRam("grant", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        pendRv = 1'b0;
        nextCyc();
        // Scramble the request fields to show they were captured at the handshake.
        i_ldValid = 1'b0;
        i_ldWrite = 1'($urandom);
        i_ldAddr  = 8'($urandom);
        i_ldWData = 8'($urandom);
        if (dropReq) i_ldReq = 1'b0;
        @(negedge i_clk);
        expRam("addr", 1'b1, 1'b1, 1'b0, 1'b1, a);
        checkEq("addr.stall", 32'(o_cpuStall), 1);
        checkEq("addr.rvalid", 32'(o_ldRValid), 0);
        nextCyc();
        @(negedge i_clk);
        if (wr) expRam("dataW", 1'b0, 1'b0, 1'b0, 1'b1, d);
        else    expRam("dataR", 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        checkEq("data.gnt", 32'(o_ldGnt), 1);
        nextCyc();
        if (wr) begin
            shadow[a] = d;
        end else begin
            pendRv   = 1'b1;
            pendData = shadow[a];
        end
    endtask

    // GRANT cycle in which the loader must lose the RAM.
    task automatic leaveGrant(input string tag);
        i_ldValid = 1'b1;
        @(negedge i_clk);
        checkEq({tag, ".ready"}, 32'(o_ldReady), 0);
        checkEq({tag, ".gnt"}, 32'(o_ldGnt), 1);
        checkEq({tag, ".stall"}, 32'(o_cpuStall), 1);
        checkEq({tag, ".rvalid"}, 32'(o_ldRValid), 32'(pendRv));
        if (pendRv) checkEq({tag, ".rdata"}, 32'(o_ldRData), 32'(pendData));
        expRam(tag, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        pendRv = 1'b0;
        nextCyc();
        i_ldValid = 1'b0;
    endtask

    // Cycles with the CPU owning the RAM; holdBoundary parks the step on the boundary.
    task automatic cool(input string tag, input int n, input bit holdBoundary);
        for (int k = 0; k < n; k++) begin
            randCpu();
            if (holdBoundary) begin
                cpuRun = 1'b0;
                i_cpuStep = STALL;
            end else begin
                cpuRun = 1'b1;
            end
            @(negedge i_clk);
            checkEq({tag, ".stall"}, 32'(o_cpuStall), 0);
            checkEq({tag, ".rvalid"}, 32'(o_ldRValid), 0);
            chkPass(tag);
            nextCyc();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        bit         wr;
        bit         dropLast;
        int         nAcc;
        logic [7:0] a;

        i_nReset = 1'b0;
        i_cpuStep = 3'd0;
        i_cpuRamAddressEn = 1'b1;
        i_cpuRamWriteNEn = 1'b0;
        i_cpuRamOE = 1'b1;
        i_ldReq = 1'b0; i_ldValid = 1'b0; i_ldWrite = 1'b0;
        i_ldAddr = 8'h00; i_ldWData = 8'h00;

        // Reset state, with CPU strobes active to show reset overrides them.
        @(negedge i_clk);
        checkEq("reset.stall", 32'(o_cpuStall), 0);
        checkEq("reset.gnt", 32'(o_ldGnt), 0);
        checkEq("reset.ready", 32'(o_ldReady), 0);
        checkEq("reset.rvalid", 32'(o_ldRValid), 0);
        checkEq("reset.rdata", 32'(o_ldRData), 0);
        checkEq("reset.busData", 32'(o_busData), 0);
        expRam("reset", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        @(posedge i_clk); #1;
        i_nReset = 1'b1;

        // Boundary wait from step 3, then write 0x12=0xAB and read it back.
        i_cpuStep = 3'd3;
        acquire(1'b0);
        access(1'b1, 8'h12, 8'hAB, 1'b0);
        access(1'b0, 8'h12, 8'h00, 1'b0);
        i_ldReq = 1'b0;
        leaveGrant("rwExit");
        cool("rwCool", 9, 1'b0);

        // Burst limit: 20 back-to-back writes with the request held throughout.
        i_cpuStep = 3'd3;
        acquire(1'b0);
        accCnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (accCnt == 16) begin
                leaveGrant("burstLimit");
                cool("burstCool", 9, 1'b1);
                acquire(1'b1);
                accCnt = 0;
            end
            access(1'b1, 8'h80 + 8'(i), 8'($urandom), 1'b0);
            accCnt++;
        end
        i_ldReq = 1'b0;
        leaveGrant("burstExit");
        cool("burstEndCool", 9, 1'b0);

        // Request drop during ADDR: read still completes, then GRANT -> COOL.
        acquire(1'b0);
        access(1'b0, 8'h85, 8'h00, 1'b1);
        leaveGrant("dropExit");
        cool("dropCool", 9, 1'b0);

        // Reset pulsed in the data cycle of a write.
        i_cpuRamAddressEn = 1'b0; i_cpuRamWriteNEn = 1'b1; i_cpuRamOE = 1'b0;
        acquire(1'b0);
        i_cpuRamAddressEn = 1'b0; i_cpuRamWriteNEn = 1'b1; i_cpuRamOE = 1'b0;
        i_ldValid = 1'b1; i_ldWrite = 1'b1; i_ldAddr = 8'h40; i_ldWData = 8'h5A;
        @(negedge i_clk);
        checkEq("rstW.ready", 32'(o_ldReady), 1);
        nextCyc();
        i_ldValid = 1'b0;
        @(negedge i_clk);
        checkEq("rstW.addrEn", 32'(o_ramAddressEn), 1);
        nextCyc();
        @(negedge i_clk);
        checkEq("rstW.writeNBefore", 32'(o_ramWriteNEn), 0);
        #1;
        i_nReset = 1'b0;
        i_ldReq = 1'b0;
        #1;
        checkEq("rstW.writeNAfter", 32'(o_ramWriteNEn), 1);
        checkEq("rstW.gnt", 32'(o_ldGnt), 0);
        checkEq("rstW.stall", 32'(o_cpuStall), 0);
        checkEq("rstW.drive", 32'(o_busDrive), 0);
        @(posedge i_clk); #1;
        i_nReset = 1'b1;
        pendRv = 1'b0;
        cool("rstW.after", 4, 1'b0);

        // Pass-through with no request and random CPU activity.
        cpuRun = 1'b0;
        for (int i = 0; i < 200; i++) begin
            randCpu();
            i_cpuStep = 3'($urandom);
            i_ldValid = 1'($urandom);
            @(negedge i_clk);
            checkEq("pass.stall", 32'(o_cpuStall), 0);
            chkPass("pass");
            nextCyc();
        end
        i_ldValid = 1'b0;

        // Random loader sessions over a small address window.
        for (int s = 0; s < 10; s++) begin
            nAcc = $urandom_range(1, 6);
            dropLast = 1'($urandom);
            i_cpuStep = 3'($urandom_range(0, 7));
            acquire(1'b0);
            for (int k = 0; k < nAcc; k++) begin
                wr = 1'($urandom);
                a = 8'($urandom_range(0, 15));
                access(wr, a, 8'($urandom), dropLast && (k == nAcc - 1));
            end
            i_ldReq = 1'b0;
            leaveGrant("sessExit");
            cool("sessCool", 9, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
